// File: rtl/cifra_bloco_iterativa.sv
// -----------------------------------------------------------------------------
// cifra_bloco_iterativa
// Iterative AES encryption core (AES-128/192/256 selected by NK). One full
// round is applied per clock to a single 128-bit state register; the round key
// is taken from a flat expanded-key bus, and MixColumns is skipped in the last
// round.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   entrada_valida  bloco_entrada is valid
//   entrada_pronta  core can accept a block this cycle
//   bloco_entrada   plaintext, byte 0 at [127:120], s[r][c] = byte 4c+r
//   chaveExpandida  round key k at [LARGURA_CHAVE-1-128k -: 128]
//   saida_valida    bloco_saida holds a finished ciphertext
//   saida_pronta    consumer accepts bloco_saida
//   bloco_saida     ciphertext, same byte order as the input
//   ocupado         high while a block is in flight or waiting to be taken
//   rodada_atual    current round counter (debug)
// -----------------------------------------------------------------------------
module cifra_bloco_iterativa #(
    parameter  int NK            = 4,
    localparam int NR            = NK + 6,
    localparam int LARGURA_CHAVE = 128 * (NR + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     entrada_valida,
    output logic                     entrada_pronta,
    input  logic [127:0]             bloco_entrada,
    input  logic [LARGURA_CHAVE-1:0] chaveExpandida,
    output logic                     saida_valida,
    input  logic                     saida_pronta,
    output logic [127:0]             bloco_saida,
    output logic                     ocupado,
    output logic [3:0]               rodada_atual
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_invalido
        $error("cifra_bloco_iterativa: NK must be 4, 6 or 8");
    end

    localparam logic [3:0] NR_W = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {OCIOSO, RODADA, PRONTO} estado_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] substituiBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Row r rotates left by r: s'[r][c] = s[r][(c+r) mod 4].
    function automatic logic [127:0] rotacionaLinhas(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] multiplicaColunas(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    estado_t      estado_q;
    logic [127:0] estado_bloco_q;
    logic [3:0]   rodada_q;
    logic         saida_valida_q;
    logic         ocupado_q;

    logic [127:0] chave_rodada;
    logic [127:0] chave_zero;
    logic [127:0] deslocado;
    logic [127:0] estado_bloco_d;
    logic         ultima_rodada;
    logic         aceita;

    // Round-key mux; indices above NR fall through to zero.
    always_comb begin
        chave_rodada = '0;
        for (int k = 0; k <= NR; k++)
            if (rodada_q == 4'(k)) chave_rodada = chaveExpandida[LARGURA_CHAVE-1-128*k -: 128];
    end

    assign chave_zero    = chaveExpandida[LARGURA_CHAVE-1 -: 128];
    assign ultima_rodada = (rodada_q == NR_W);
    assign deslocado     = rotacionaLinhas(substituiBytes(estado_bloco_q));

    always_comb begin
        estado_bloco_d = (ultima_rodada ? deslocado : multiplicaColunas(deslocado)) ^ chave_rodada;
    end

    // Ready also while PRONTO is being drained, so blocks can run back-to-back.
    assign entrada_pronta = (estado_q == OCIOSO) || (estado_q == PRONTO && saida_pronta);
    assign aceita         = entrada_valida && entrada_pronta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= OCIOSO;
            estado_bloco_q <= '0;
            rodada_q       <= '0;
            saida_valida_q <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (aceita) begin
                        estado_bloco_q <= bloco_entrada ^ chave_zero;
                        rodada_q       <= 4'd1;
                        ocupado_q      <= 1'b1;
                        estado_q       <= RODADA;
                    end
                end
                RODADA: begin
                    estado_bloco_q <= estado_bloco_d;
                    if (ultima_rodada) begin
                        saida_valida_q <= 1'b1;
                        estado_q       <= PRONTO;
                    end else begin
                        rodada_q <= rodada_q + 4'd1;
                    end
                end
                PRONTO: begin
                    if (saida_pronta) begin
                        saida_valida_q <= 1'b0;
                        if (entrada_valida) begin
                            estado_bloco_q <= bloco_entrada ^ chave_zero;
                            rodada_q       <= 4'd1;
                            estado_q       <= RODADA;
                        end else begin
                            rodada_q  <= 4'd0;
                            ocupado_q <= 1'b0;
                            estado_q  <= OCIOSO;
                        end
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign saida_valida = saida_valida_q;
    assign bloco_saida  = estado_bloco_q;
    assign ocupado      = ocupado_q;
    assign rodada_atual = rodada_q;

endmodule

// File: tb/tb_cifra_bloco_iterativa.sv
// -----------------------------------------------------------------------------
// tb_cifra_bloco_iterativa
// Directed bench for the iterative AES core. Expanded keys are built here from
// a field-arithmetic S-box; expected ciphertexts are the published AES vectors.
// A negedge monitor on the NK=4 instance tracks acceptances and outputs and
// pops expectations from a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_cifra_bloco_iterativa;

    logic clk;
    logic rst;

    logic           ev4, ep4, sv4, sp4, oc4;
    logic [127:0]   bi4, bo4;
    logic [1407:0]  ck4;
    logic [3:0]     ra4;

    logic           ev6, ep6, sv6, sp6, oc6;
    logic [127:0]   bi6, bo6;
    logic [1663:0]  ck6;
    logic [3:0]     ra6;

    logic           ev8, ep8, sv8, sp8, oc8;
    logic [127:0]   bi8, bo8;
    logic [1919:0]  ck8;
    logic [3:0]     ra8;

    cifra_bloco_iterativa #(.NK(4)) u4 (
        .clk(clk), .rst(rst), .entrada_valida(ev4), .entrada_pronta(ep4),
        .bloco_entrada(bi4), .chaveExpandida(ck4), .saida_valida(sv4),
        .saida_pronta(sp4), .bloco_saida(bo4), .ocupado(oc4), .rodada_atual(ra4));

    cifra_bloco_iterativa #(.NK(6)) u6 (
        .clk(clk), .rst(rst), .entrada_valida(ev6), .entrada_pronta(ep6),
        .bloco_entrada(bi6), .chaveExpandida(ck6), .saida_valida(sv6),
        .saida_pronta(sp6), .bloco_saida(bo6), .ocupado(oc6), .rodada_atual(ra6));

    cifra_bloco_iterativa #(.NK(8)) u8 (
        .clk(clk), .rst(rst), .entrada_valida(ev8), .entrada_pronta(ep8),
        .bloco_entrada(bi8), .chaveExpandida(ck8), .saida_valida(sv8),
        .saida_pronta(sp8), .bloco_saida(bo8), .ocupado(oc8), .rodada_atual(ra8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    int last_rise = 0;
    logic sv_prev = 1'b0;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           rise_log [$];
    logic [7:0]   sb [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] r  = '0;
        int total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) r[1919-32*i -: 32] = w[i];
        return r;
    endfunction

    // ---------------- NK=4 monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ev4 && ep4) acc_q.push_back(cyc + 1);
            if (sv4 && !sv_prev) begin
                last_rise = cyc;
                rise_log.push_back(cyc);
            end
            if (sv4 && sp4) begin
                checks++;
                assert (exp_q.size() > 0 && acc_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_output: observed %h expected none", bo4);
                end
                if (exp_q.size() > 0 && acc_q.size() > 0) begin
                    chk("ciphertext", bo4, exp_q.pop_front());
                    chk("latency", 128'(last_rise - acc_q.pop_front()), 128'(10));
                end
                n_out++;
            end
        end
        sv_prev = sv4;
    end

    task automatic wait_sv4(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sv4 && k < 40);
        if (!sv4) tmo(tag);
    endtask

    task automatic wait_out(input int target, input string tag);
        int k = 0;
        while (n_out < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (n_out < target) tmo(tag);
    endtask

    task automatic send4(input logic [127:0] pt, input logic [255:0] key, input logic [127:0] ct);
        logic [1919:0] ek;
        ek = expand(key, 4);
        @(posedge clk); #1;
        ck4 = ek[1919 -: 1408];
        bi4 = pt;
        ev4 = 1'b1;
        exp_q.push_back(ct);
        @(posedge clk); #1;
        ev4 = 1'b0;
    endtask

    initial begin
        logic [1919:0] ek;
        int k;
        int lat;
        int base;

        rst = 1'b0;
        ev4 = 0; sp4 = 1; bi4 = '0; ck4 = '0;
        ev6 = 0; sp6 = 1; bi6 = '0; ck6 = '0;
        ev8 = 0; sp8 = 1; bi8 = '0; ck8 = '0;
        build_sbox();
        #2 rst = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_saida_valida", 128'(sv4), 128'(0));
        chk("rst_bloco_saida", bo4, 128'h0);
        chk("rst_ocupado", 128'(oc4), 128'(0));
        chk("rst_rodada", 128'(ra4), 128'(0));
        rst = 1'b0;
        #1 chk("rst_entrada_pronta", 128'(ep4), 128'(1));

        // NK=4 vector 1, plus PRONTO status
        send4(PT1, KEY1, CT1);
        wait_sv4("t1_valid");
        chk("t1_rodada_pronto", 128'(ra4), 128'(10));
        chk("t1_ocupado", 128'(oc4), 128'(1));
        wait_out(1, "t1_out");

        // NK=4 vector 2 with consumer stalled for 5 cycles
        sp4 = 1'b0;
        send4(PT2, KEY2, CT2);
        wait_sv4("t2_valid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_bloco", bo4, CT2);
            chk("hold_valida", 128'(sv4), 128'(1));
            chk("hold_entrada_pronta", 128'(ep4), 128'(0));
            @(negedge clk);
        end
        @(posedge clk); #1 sp4 = 1'b1;
        wait_out(2, "t2_out");
        @(negedge clk);
        chk("t2_ocioso_rodada", 128'(ra4), 128'(0));

        // NK=6
        ek = expand(KEY6, 6);
        @(posedge clk); #1;
        ck6 = ek[1919 -: 1664]; bi6 = PT1; ev6 = 1'b1;
        chk("nk6_pronta", 128'(ep6), 128'(1));
        @(posedge clk); #1 ev6 = 1'b0;
        lat = -1;
        for (k = 1; k <= 30 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (sv6) lat = k;
        end
        if (lat < 0) tmo("nk6_valid");
        else begin
            chk("nk6_latency", 128'(lat), 128'(12));
            chk("nk6_ciphertext", bo6, CT6);
        end

        // NK=8
        ek = expand(KEY8, 8);
        @(posedge clk); #1;
        ck8 = ek; bi8 = PT1; ev8 = 1'b1;
        @(posedge clk); #1 ev8 = 1'b0;
        lat = -1;
        for (k = 1; k <= 30 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (sv8) lat = k;
        end
        if (lat < 0) tmo("nk8_valid");
        else begin
            chk("nk8_latency", 128'(lat), 128'(14));
            chk("nk8_ciphertext", bo8, CT8);
        end

        // back-to-back with valid held high
        base = n_out;
        ek = expand(KEY1, 4);
        @(posedge clk); #1;
        ck4 = ek[1919 -: 1408]; bi4 = PT1; ev4 = 1'b1;
        exp_q.push_back(CT1);
        exp_q.push_back(CT2);
        wait_sv4("b2b_first");
        ek = expand(KEY2, 4);
        ck4 = ek[1919 -: 1408]; bi4 = PT2;
        @(posedge clk); #1 ev4 = 1'b0;
        wait_out(base + 2, "b2b_out");
        if (rise_log.size() >= 2)
            chk("b2b_spacing", 128'(rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2]), 128'(11));
        else tmo("b2b_spacing");

        // reset in round 5 aborts the block
        base = n_out;
        send4(PT1, KEY1, CT1);
        k = 0;
        while (ra4 != 4'd5 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (ra4 != 4'd5) tmo("rst_round5");
        rst = 1'b1;
        #1;
        chk("abort_saida_valida", 128'(sv4), 128'(0));
        chk("abort_bloco_saida", bo4, 128'h0);
        chk("abort_rodada", 128'(ra4), 128'(0));
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send4(PT2, KEY2, CT2);
        wait_out(base + 1, "after_rst_out");

        // valid pulsed while busy is ignored
        base = n_out;
        send4(PT1, KEY1, CT1);
        repeat (2) @(posedge clk);
        #1;
        bi4 = PT2; ev4 = 1'b1;
        chk("busy_entrada_pronta", 128'(ep4), 128'(0));
        repeat (2) @(posedge clk);
        #1 ev4 = 1'b0; bi4 = PT1;
        wait_out(base + 1, "pulse_out");
        repeat (30) @(negedge clk);
        chk("pulse_no_extra_output", 128'(n_out), 128'(base + 1));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
